// File: rtl/run_controller.sv
// run_controller
//
// Upstream control stage for the singlecycle processor. Holds the processor
// in reset with a latched start PC, releases it, runs it until currentpc
// reaches the latched stop address, then captures MemtoRegOut and compares it
// against a latched expected value. A watchdog ends runs that never reach the
// stop address.
//
// Ports:
//   CLK          in   clock, all state updates on posedge
//   resetl       in   asynchronous active-low reset
//   start        in   run request, accepted in IDLE or DONE
//   startpc_in   in   PC loaded into the processor
//   stoppc_in    in   run ends when currentpc >= this (unsigned)
//   expected_in  in   value MemtoRegOut must equal at the stop point
//   currentpc    in   processor current PC
//   MemtoRegOut  in   processor writeback value
//   cpu_resetl   out  processor reset, active low
//   startpc      out  latched processor start PC
//   busy         out  high in HOLD and RUN
//   done         out  run finished, held until next start
//   pass         out  stop PC hit with matching result (valid with done)
//   timeout      out  watchdog expired (valid with done)
//   result       out  MemtoRegOut captured at the stop point
//   cycles       out  non-terminating RUN cycles of the current/last run
module run_controller #(
  parameter int                  RESET_CYCLES = 2,
  parameter int                  WD_WIDTH     = 16,
  parameter logic [WD_WIDTH-1:0] WD_LIMIT     = 16'h00FF,
  parameter int                  DATA_W       = 64
) (
  input  logic                CLK,
  input  logic                resetl,
  input  logic                start,
  input  logic [DATA_W-1:0]   startpc_in,
  input  logic [DATA_W-1:0]   stoppc_in,
  input  logic [DATA_W-1:0]   expected_in,
  input  logic [DATA_W-1:0]   currentpc,
  input  logic [DATA_W-1:0]   MemtoRegOut,
  output logic                cpu_resetl,
  output logic [DATA_W-1:0]   startpc,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [DATA_W-1:0]   result,
  output logic [WD_WIDTH-1:0] cycles
);

  // The hold counter runs 0 .. RESET_CYCLES-1; the transition to RUN happens
  // on the edge that sees the last value, i.e. the RESET_CYCLES-th HOLD edge.
  localparam int                HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                cpu_resetl_q, cpu_resetl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-1:0]   startpc_q, startpc_d;
  logic [DATA_W-1:0]   stop_q, stop_d;
  logic [DATA_W-1:0]   expected_q, expected_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [WD_WIDTH-1:0] cycles_q, cycles_d;

  logic stop_hit;
  logic wd_expired;

  assign stop_hit   = (currentpc >= stop_q);
  assign wd_expired = (cycles_q == WD_LIMIT);

  // State and output registers
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      cpu_resetl_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      startpc_q    <= '0;
      stop_q       <= '0;
      expected_q   <= '0;
      result_q     <= '0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cpu_resetl_q <= cpu_resetl_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      startpc_q    <= startpc_d;
      stop_q       <= stop_d;
      expected_q   <= expected_d;
      result_q     <= result_d;
      cycles_q     <= cycles_d;
    end
  end

  // Next-state and next-output logic; every output is registered, so the
  // values computed here are what the outputs show after the coming edge.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    cpu_resetl_d = cpu_resetl_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    startpc_d    = startpc_q;
    stop_d       = stop_q;
    expected_d   = expected_q;
    result_d     = result_q;
    cycles_d     = cycles_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        cpu_resetl_d = 1'b0;
        busy_d       = 1'b0;
        if (start) begin
          startpc_d  = startpc_in;
          stop_d     = stoppc_in;
          expected_d = expected_in;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          result_d   = '0;
          cycles_d   = '0;
          hold_d     = '0;
          busy_d     = 1'b1;
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        busy_d       = 1'b1;
        cpu_resetl_d = 1'b0;
        hold_d       = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          cpu_resetl_d = 1'b1;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        busy_d       = 1'b1;
        cpu_resetl_d = 1'b1;
        // Stop hit outranks the watchdog when both occur on the same edge.
        if (stop_hit) begin
          result_d     = MemtoRegOut;
          pass_d       = (MemtoRegOut == expected_q);
          timeout_d    = 1'b0;
          done_d       = 1'b1;
          cpu_resetl_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = S_DONE;
        end else if (wd_expired) begin
          timeout_d    = 1'b1;
          pass_d       = 1'b0;
          done_d       = 1'b1;
          cpu_resetl_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = S_DONE;
        end else begin
          // Cannot wrap: the watchdog branch above fires at WD_LIMIT.
          cycles_d = cycles_q + 1'b1;
        end
      end

      default: begin
        state_d      = S_IDLE;
        cpu_resetl_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  assign cpu_resetl = cpu_resetl_q;
  assign startpc    = startpc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign result     = result_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        start;
  logic [63:0] startpc_in;
  logic [63:0] stoppc_in;
  logic [63:0] expected_in;
  logic [63:0] currentpc = 64'd0;
  logic [63:0] MemtoRegOut;
  logic        cpu_resetl;
  logic [63:0] startpc;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [63:0] result;
  logic [15:0] cycles;

  // Processor model controls
  logic        freeze = 1'b0;
  logic [63:0] tb_stop = 64'd0;
  logic [63:0] tb_mem  = 64'd0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [63:0] result;
    logic [15:0] cycles;
  } exp_t;

  typedef struct {
    logic [63:0] spc;
    logic [63:0] stp;
    logic [63:0] expv;
    logic [63:0] mem;
    logic        frz;
    exp_t        out;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  run_controller #(
    .RESET_CYCLES(2),
    .WD_WIDTH(16),
    .WD_LIMIT(16'h00FF),
    .DATA_W(64)
  ) dut (
    .CLK(CLK),
    .resetl(resetl),
    .start(start),
    .startpc_in(startpc_in),
    .stoppc_in(stoppc_in),
    .expected_in(expected_in),
    .currentpc(currentpc),
    .MemtoRegOut(MemtoRegOut),
    .cpu_resetl(cpu_resetl),
    .startpc(startpc),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .result(result),
    .cycles(cycles)
  );

  always #5 CLK = ~CLK;

  // Processor model: PC held at startpc while in reset, else advances by 4
  // per clock unless frozen. Writeback value is the programmed result once the
  // PC is at/after the stop address, junk otherwise.
  always @(posedge CLK) begin
    if (!cpu_resetl)
      currentpc <= startpc;
    else if (!freeze)
      currentpc <= currentpc + 64'd4;
  end

  assign MemtoRegOut = (currentpc >= tb_stop) ? tb_mem : 64'hDEAD_BEEF_0BAD_F00D;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic do_start(input logic [63:0] spc, input logic [63:0] stp, input logic [63:0] expv);
    @(negedge CLK);
    startpc_in  = spc;
    stoppc_in   = stp;
    expected_in = expv;
    start       = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Pops the oldest expected outcome and compares it with the finished run.
  task automatic wait_and_score(input string tag, input int budget);
    bit   ok;
    exp_t e;
    wait_done(budget, ok);
    check({tag, "_done_reached"}, {63'd0, ok}, 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_pass"},       {63'd0, pass},    {63'd0, e.pass});
      check({tag, "_timeout"},    {63'd0, timeout}, {63'd0, e.timeout});
      check({tag, "_result"},     result,           e.result);
      check({tag, "_cycles"},     {48'd0, cycles},  {48'd0, e.cycles});
      check({tag, "_cpu_resetl"}, {63'd0, cpu_resetl}, 64'd0);
      check({tag, "_busy"},       {63'd0, busy},    64'd0);
    end
  endtask

  task automatic run_vec(input int idx);
    string tag;
    tag    = $sformatf("vec%0d", idx);
    tb_stop = vecs[idx].stp;
    tb_mem  = vecs[idx].mem;
    freeze  = vecs[idx].frz;
    do_start(vecs[idx].spc, vecs[idx].stp, vecs[idx].expv);
    sb.push_back(vecs[idx].out);
    check({tag, "_busy_after_start"}, {63'd0, busy}, 64'd1);
    check({tag, "_startpc"}, startpc, vecs[idx].spc);
    wait_and_score(tag, 600);
    // DONE must hold its results while start stays low.
    repeat (2) @(negedge CLK);
    check({tag, "_done_hold"},   {63'd0, done}, 64'd1);
    check({tag, "_result_hold"}, result, vecs[idx].out.result);
  endtask

  initial begin
    bit ok;

    vecs[0] = '{spc: 64'h0,   stp: 64'h30, expv: 64'hF, mem: 64'hF, frz: 1'b0,
                out: '{pass: 1'b1, timeout: 1'b0, result: 64'hF, cycles: 16'd12}};
    vecs[1] = '{spc: 64'h0,   stp: 64'h30, expv: 64'h1234_5678_9abc_def0, mem: 64'h0, frz: 1'b0,
                out: '{pass: 1'b0, timeout: 1'b0, result: 64'h0, cycles: 16'd12}};
    vecs[2] = '{spc: 64'h8,   stp: 64'hFFFF_FFFF_FFFF_FFFF, expv: 64'h0, mem: 64'h0, frz: 1'b1,
                out: '{pass: 1'b0, timeout: 1'b1, result: 64'h0, cycles: 16'h00FF}};
    vecs[3] = '{spc: 64'h54,  stp: 64'h54, expv: 64'h1234_5678_9abc_def0,
                mem: 64'h1234_5678_9abc_def0, frz: 1'b0,
                out: '{pass: 1'b1, timeout: 1'b0, result: 64'h1234_5678_9abc_def0, cycles: 16'd0}};
    vecs[4] = '{spc: 64'h100, stp: 64'h120, expv: 64'hAA, mem: 64'hAB, frz: 1'b0,
                out: '{pass: 1'b0, timeout: 1'b0, result: 64'hAB, cycles: 16'd8}};

    resetl      = 1'b0;
    start       = 1'b0;
    startpc_in  = 64'h0;
    stoppc_in   = 64'h0;
    expected_in = 64'h0;

    // Reset state
    #12;
    check("rst_cpu_resetl", {63'd0, cpu_resetl}, 64'd0);
    check("rst_busy",       {63'd0, busy},       64'd0);
    check("rst_done",       {63'd0, done},       64'd0);
    check("rst_pass",       {63'd0, pass},       64'd0);
    check("rst_timeout",    {63'd0, timeout},    64'd0);
    check("rst_startpc",    startpc,             64'd0);
    check("rst_result",     result,              64'd0);
    check("rst_cycles",     {48'd0, cycles},     64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    @(negedge CLK);

    // First run with cpu_resetl release timing
    tb_stop = 64'h30;
    tb_mem  = 64'hF;
    freeze  = 1'b0;
    do_start(64'h0, 64'h30, 64'hF);
    sb.push_back(vecs[0].out);
    check("hold_busy",        {63'd0, busy},       64'd1);
    check("hold_cpu_resetl0", {63'd0, cpu_resetl}, 64'd0);
    @(negedge CLK);
    check("hold_cpu_resetl1", {63'd0, cpu_resetl}, 64'd0);
    @(negedge CLK);
    check("run_cpu_resetl",   {63'd0, cpu_resetl}, 64'd1);
    check("run_busy",         {63'd0, busy},       64'd1);
    wait_and_score("timing", 100);

    // Table-driven runs, each starting from DONE
    for (int i = 0; i < 5; i++) run_vec(i);

    // start pulsed in RUN is ignored
    tb_stop = 64'h30;
    tb_mem  = 64'hF;
    freeze  = 1'b0;
    do_start(64'h0, 64'h30, 64'hF);
    sb.push_back(vecs[0].out);
    repeat (6) @(negedge CLK);
    startpc_in  = 64'h200;
    stoppc_in   = 64'h8;
    expected_in = 64'h1;
    start       = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("ignrun_busy",    {63'd0, busy}, 64'd1);
    check("ignrun_done",    {63'd0, done}, 64'd0);
    check("ignrun_startpc", startpc,       64'd0);
    wait_and_score("ignrun", 100);

    // start in DONE clears status on the accepting edge
    tb_stop = vecs[4].stp;
    tb_mem  = vecs[4].mem;
    do_start(vecs[4].spc, vecs[4].stp, vecs[4].expv);
    sb.push_back(vecs[4].out);
    check("redo_done_clr",   {63'd0, done},   64'd0);
    check("redo_pass_clr",   {63'd0, pass},   64'd0);
    check("redo_result_clr", result,          64'd0);
    check("redo_cycles_clr", {48'd0, cycles}, 64'd0);
    check("redo_busy",       {63'd0, busy},   64'd1);
    wait_and_score("redo", 100);

    // Asynchronous reset in the middle of RUN
    tb_stop = 64'h30;
    tb_mem  = 64'hF;
    do_start(64'h40, 64'h400, 64'hF);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cycles == 16'd5) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("midrst_reached_5", {63'd0, ok}, 64'd1);
    resetl = 1'b0;
    #1;
    check("midrst_cpu_resetl", {63'd0, cpu_resetl}, 64'd0);
    check("midrst_busy",       {63'd0, busy},       64'd0);
    check("midrst_done",       {63'd0, done},       64'd0);
    check("midrst_cycles",     {48'd0, cycles},     64'd0);
    check("midrst_result",     result,              64'd0);
    check("midrst_startpc",    startpc,             64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    repeat (3) @(negedge CLK);
    check("postrst_idle_busy", {63'd0, busy},       64'd0);
    check("postrst_idle_cpu",  {63'd0, cpu_resetl}, 64'd0);
    check("postrst_idle_done", {63'd0, done},       64'd0);
    run_vec(0);

    check("sb_drained", {32'd0, sb.size()}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
